// File: rtl/mul_issue_arbiter.sv
// Round-robin issue of two requesters into one fixed-latency pipelined multiplier, in-order tagged responses.
// Latency MUL_LAT+1 cycles accept->rsp_valid_o; a held response stalls issue, shadow pipe and the multiplier.
module mul_issue_arbiter #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [2:0]       req0_funct3_i,
    input  logic [XLEN-1:0]  req0_rs1_i,
    input  logic [XLEN-1:0]  req0_rs2_i,
    input  logic [TAG_W-1:0] req0_tag_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [2:0]       req1_funct3_i,
    input  logic [XLEN-1:0]  req1_rs1_i,
    input  logic [XLEN-1:0]  req1_rs2_i,
    input  logic [TAG_W-1:0] req1_tag_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_src_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic [XLEN-1:0]  rsp_result_o,
    output logic             rsp_err_o,

    output logic             mul_stall_o,
    output logic [2:0]       mul_funct3_o,
    output logic [XLEN-1:0]  mul_rs1_o,
    output logic [XLEN-1:0]  mul_rs2_o,
    input  logic [XLEN-1:0]  mul_result_i,

    output logic             busy_o
);

    localparam int LAST = MUL_LAT - 1;

    typedef struct packed {
        logic             vld;
        logic             src;
        logic [TAG_W-1:0] tag;
        logic             err;
    } shadow_t;

    typedef struct packed {
        logic             vld;
        logic             src;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [XLEN-1:0]  result;
    } rsp_t;

    logic             stall;
    logic             prefer1;
    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic [2:0]       sel_funct3;
    logic [XLEN-1:0]  sel_rs1;
    logic [XLEN-1:0]  sel_rs2;
    logic [TAG_W-1:0] sel_tag;

    logic             last_src_q, last_src_d;
    logic             served_q, served_d;
    logic [2:0]       mul_funct3_q, mul_funct3_d;
    logic [XLEN-1:0]  mul_rs1_q, mul_rs1_d;
    logic [XLEN-1:0]  mul_rs2_q, mul_rs2_d;
    shadow_t          sh_q [MUL_LAT];
    shadow_t          sh_d [MUL_LAT];
    rsp_t             rsp_q, rsp_d;
    logic             inflight;

    assign stall = rsp_q.vld & ~rsp_ready_i;

    // Until the first grant the pointer is meaningless, so req0 wins the first tie.
    assign prefer1 = served_q & ~last_src_q;
    assign gnt1    = req1_valid_i & (~req0_valid_i | prefer1);
    assign gnt0    = req0_valid_i & ~gnt1;

    assign req0_ready_o = gnt0 & ~stall;
    assign req1_ready_o = gnt1 & ~stall;
    assign accept       = (gnt0 | gnt1) & ~stall;

    assign sel_funct3 = gnt1 ? req1_funct3_i : req0_funct3_i;
    assign sel_rs1    = gnt1 ? req1_rs1_i    : req0_rs1_i;
    assign sel_rs2    = gnt1 ? req1_rs2_i    : req0_rs2_i;
    assign sel_tag    = gnt1 ? req1_tag_i    : req0_tag_i;

    always_comb begin
        last_src_d   = last_src_q;
        served_d     = served_q;
        mul_funct3_d = mul_funct3_q;
        mul_rs1_d    = mul_rs1_q;
        mul_rs2_d    = mul_rs2_q;
        sh_d[0]      = '0;
        if (accept) begin
            last_src_d   = gnt1;
            served_d     = 1'b1;
            mul_funct3_d = sel_funct3;
            mul_rs1_d    = sel_rs1;
            mul_rs2_d    = sel_rs2;
            sh_d[0]      = '{vld: 1'b1, src: gnt1, tag: sel_tag, err: sel_funct3[2]};
        end
        for (int i = 1; i < MUL_LAT; i++) begin
            sh_d[i] = sh_q[i-1];
        end
    end

    // Only applied when not stalled, so the held response was either empty or consumed.
    always_comb begin
        rsp_d = '0;
        if (sh_q[LAST].vld) begin
            rsp_d.vld    = 1'b1;
            rsp_d.src    = sh_q[LAST].src;
            rsp_d.tag    = sh_q[LAST].tag;
            rsp_d.err    = sh_q[LAST].err;
            rsp_d.result = sh_q[LAST].err ? '0 : mul_result_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_src_q   <= 1'b0;
            served_q     <= 1'b0;
            mul_funct3_q <= '0;
            mul_rs1_q    <= '0;
            mul_rs2_q    <= '0;
            rsp_q        <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                sh_q[i] <= '0;
            end
        end else if (!stall) begin
            last_src_q   <= last_src_d;
            served_q     <= served_d;
            mul_funct3_q <= mul_funct3_d;
            mul_rs1_q    <= mul_rs1_d;
            mul_rs2_q    <= mul_rs2_d;
            rsp_q        <= rsp_d;
            for (int i = 0; i < MUL_LAT; i++) begin
                sh_q[i] <= sh_d[i];
            end
        end
    end

    always_comb begin
        inflight = rsp_q.vld;
        for (int i = 0; i < MUL_LAT; i++) begin
            inflight = inflight | sh_q[i].vld;
        end
    end

    assign rsp_valid_o  = rsp_q.vld;
    assign rsp_src_o    = rsp_q.src;
    assign rsp_tag_o    = rsp_q.tag;
    assign rsp_err_o    = rsp_q.err;
    assign rsp_result_o = rsp_q.result;
    assign mul_stall_o  = stall;
    assign mul_funct3_o = mul_funct3_q;
    assign mul_rs1_o    = mul_rs1_q;
    assign mul_rs2_o    = mul_rs2_q;
    assign busy_o       = inflight;

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Bench for mul_issue_arbiter: behavioural multiplier stand-in plus a queue/age reference model.
module tb_mul_issue_arbiter;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req0_valid_i, req0_ready_o;
    logic [2:0]       req0_funct3_i;
    logic [XLEN-1:0]  req0_rs1_i, req0_rs2_i;
    logic [TAG_W-1:0] req0_tag_i;
    logic             req1_valid_i, req1_ready_o;
    logic [2:0]       req1_funct3_i;
    logic [XLEN-1:0]  req1_rs1_i, req1_rs2_i;
    logic [TAG_W-1:0] req1_tag_i;
    logic             rsp_valid_o, rsp_ready_i, rsp_src_o, rsp_err_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic [XLEN-1:0]  rsp_result_o;
    logic             mul_stall_o;
    logic [2:0]       mul_funct3_o;
    logic [XLEN-1:0]  mul_rs1_o, mul_rs2_o, mul_result_i;
    logic             busy_o;

    always #5 clk = ~clk;

    mul_issue_arbiter #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_funct3_i(req0_funct3_i),
        .req0_rs1_i(req0_rs1_i), .req0_rs2_i(req0_rs2_i), .req0_tag_i(req0_tag_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_funct3_i(req1_funct3_i),
        .req1_rs1_i(req1_rs1_i), .req1_rs2_i(req1_rs2_i), .req1_tag_i(req1_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_src_o(rsp_src_o),
        .rsp_tag_o(rsp_tag_o), .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
        .mul_stall_o(mul_stall_o), .mul_funct3_o(mul_funct3_o), .mul_rs1_o(mul_rs1_o),
        .mul_rs2_o(mul_rs2_o), .mul_result_i(mul_result_i), .busy_o(busy_o)
    );

    // Stand-in mul_unit: signed-extension product, garbage for DIV/REM encodings.
    function automatic logic [XLEN-1:0] mu_calc(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [XLEN:0]     ea, eb;
        logic signed [2*XLEN+1:0] p;
        ea = (f[1:0] == 2'b11) ? {1'b0, a} : {a[XLEN-1], a};
        eb = (f[1:0] == 2'b01) ? {b[XLEN-1], b} : {1'b0, b};
        p  = ea * eb;
        if (f[2]) return a ^ b ^ 32'hDEAD_BEEF;
        return (f[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    logic [XLEN-1:0] mu_pipe [MUL_LAT-1];
    always @(posedge clk) begin
        if (!mul_stall_o) begin
            mu_pipe[0] <= mu_calc(mul_funct3_o, mul_rs1_o, mul_rs2_o);
            for (int i = 1; i < MUL_LAT - 1; i++) mu_pipe[i] <= mu_pipe[i-1];
        end
    end
    assign mul_result_i = mu_pipe[MUL_LAT-2];

    // Reference result: 64-bit unsigned product of zero/sign-extended operands.
    function automatic logic [XLEN-1:0] exp_res(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [63:0] ua, ub, p;
        if (f[2]) return '0;
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (f[1:0] == 2'b01 || f[1:0] == 2'b10) ua = {{32{a[31]}}, a};
        if (f[1:0] == 2'b01) ub = {{32{b[31]}}, b};
        p = ua * ub;
        return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    typedef struct packed {
        logic             v;
        logic [2:0]       f;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [TAG_W-1:0] t;
    } rq_t;

    typedef struct {
        logic             src;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
        logic             err;
        int               age;
    } op_t;

    int              total = 0;
    int              bad   = 0;
    op_t             mq[$];
    bit              m_last, m_served;
    logic [2:0]      m_f3;
    logic [XLEN-1:0] m_rs1, m_rs2;
    bit              acc_ok, acc_src;
    logic            obs_g1;
    logic [XLEN-1:0] got_res[$];
    rq_t             IDLE;

    function automatic rq_t mk(input logic v, input logic [2:0] f, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t);
        rq_t r;
        r.v = v; r.f = f; r.a = a; r.b = b; r.t = t;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive just after posedge, check at negedge, advance the model.
    task automatic cyc(input rq_t r0, input rq_t r1, input bit rr);
        bit  exp_rv, exp_stall, exp_r0, exp_r1, win1, any;
        rq_t w;
        op_t o;
        req0_valid_i = r0.v; req0_funct3_i = r0.f; req0_rs1_i = r0.a; req0_rs2_i = r0.b; req0_tag_i = r0.t;
        req1_valid_i = r1.v; req1_funct3_i = r1.f; req1_rs1_i = r1.a; req1_rs2_i = r1.b; req1_tag_i = r1.t;
        rsp_ready_i  = rr;
        @(negedge clk);
        exp_rv = 1'b0;
        if (mq.size() > 0) exp_rv = (mq[0].age > MUL_LAT);
        exp_stall = exp_rv && !rr;
        any  = r0.v || r1.v;
        if (r0.v && r1.v) win1 = m_served ? !m_last : 1'b0;
        else              win1 = r1.v;
        exp_r0 = any && !win1 && !exp_stall;
        exp_r1 = any && win1 && !exp_stall;
        obs_g1 = req1_ready_o;
        chk("ready0", req0_ready_o, exp_r0);
        chk("ready1", req1_ready_o, exp_r1);
        chk("stall", mul_stall_o, exp_stall);
        chk("rsp_valid", rsp_valid_o, exp_rv);
        chk("busy", busy_o, mq.size() != 0);
        chk("mul_funct3", mul_funct3_o, m_f3);
        chk("mul_rs1", mul_rs1_o, m_rs1);
        chk("mul_rs2", mul_rs2_o, m_rs2);
        if (exp_rv) begin
            chk("rsp_src", rsp_src_o, mq[0].src);
            chk("rsp_tag", rsp_tag_o, mq[0].tag);
            chk("rsp_result", rsp_result_o, mq[0].res);
            chk("rsp_err", rsp_err_o, mq[0].err);
        end
        if (rsp_valid_o && rr) got_res.push_back(rsp_result_o);
        acc_ok  = exp_r0 || exp_r1;
        acc_src = exp_r1;
        if (exp_rv && rr) void'(mq.pop_front());
        if (!exp_stall) foreach (mq[i]) mq[i].age = mq[i].age + 1;
        if (acc_ok) begin
            w = acc_src ? r1 : r0;
            o.src = acc_src; o.tag = w.t; o.res = exp_res(w.f, w.a, w.b); o.err = w.f[2]; o.age = 1;
            mq.push_back(o);
            m_last = acc_src; m_served = 1'b1;
            m_f3 = w.f; m_rs1 = w.a; m_rs2 = w.b;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_src", rsp_src_o, 0);
        chk("rst_rsp_tag", rsp_tag_o, 0);
        chk("rst_rsp_result", rsp_result_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_stall", mul_stall_o, 0);
        chk("rst_mul_f3", mul_funct3_o, 0);
        chk("rst_mul_rs1", mul_rs1_o, 0);
        chk("rst_mul_rs2", mul_rs2_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready0", req0_ready_o, 0);
        chk("rst_ready1", req1_ready_o, 0);
        mq.delete();
        m_last = 1'b0; m_served = 1'b0; m_f3 = '0; m_rs1 = '0; m_rs2 = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string name, input bit src, input logic [2:0] f, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] exp);
        rq_t r;
        bit  seen;
        r = mk(1'b1, f, a, b, t);
        cyc(src ? IDLE : r, src ? r : IDLE, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (rsp_valid_o) begin
                seen = 1'b1;
                chk({name, "_result"}, rsp_result_o, exp);
                chk({name, "_tag"}, rsp_tag_o, t);
                chk({name, "_src"}, rsp_src_o, src);
                chk({name, "_err"}, rsp_err_o, f[2]);
            end
            cyc(IDLE, IDLE, 1'b1);
        end
        chk({name, "_seen"}, seen, 1);
    endtask

    function automatic logic [XLEN-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [XLEN-1:0] exp_sq[4];
        IDLE = mk(1'b0, 3'b000, '0, '0, '0);
        req0_funct3_i = '0; req0_rs1_i = '0; req0_rs2_i = '0; req0_tag_i = '0;
        req1_funct3_i = '0; req1_rs1_i = '0; req1_rs2_i = '0; req1_tag_i = '0;
        do_reset();

        // Single MUL with explicit latency
        cyc(mk(1'b1, 3'b000, 32'd3, 32'd5, 5'd7), IDLE, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("lat_cycle%0d", k), rsp_valid_o, k == 3);
            if (k == 3) begin
                chk("first_result", rsp_result_o, 32'h0000_000F);
                chk("first_src", rsp_src_o, 0);
                chk("first_tag", rsp_tag_o, 7);
                chk("first_err", rsp_err_o, 0);
            end
            cyc(IDLE, IDLE, 1'b1);
        end

        // Alternating grants on ties
        do_reset();
        got_res.delete();
        cyc(mk(1, 0, 2, 2, 1), mk(1, 0, 3, 3, 2), 1'b1); chk("tie_g0", obs_g1, 0);
        cyc(mk(1, 0, 4, 4, 3), mk(1, 0, 3, 3, 2), 1'b1); chk("tie_g1", obs_g1, 1);
        cyc(mk(1, 0, 4, 4, 3), mk(1, 0, 5, 5, 4), 1'b1); chk("tie_g2", obs_g1, 0);
        cyc(mk(1, 0, 6, 6, 5), mk(1, 0, 5, 5, 4), 1'b1); chk("tie_g3", obs_g1, 1);
        for (int k = 0; k < 6; k++) cyc(IDLE, IDLE, 1'b1);
        exp_sq = '{32'd4, 32'd9, 32'd16, 32'd25};
        chk("tie_count", got_res.size(), 4);
        for (int k = 0; k < 4 && k < got_res.size(); k++) chk($sformatf("tie_res%0d", k), got_res[k], exp_sq[k]);

        // High-half products
        run_one("mulhu", 1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'hFFFF_FFFE);
        run_one("mulh", 1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000);

        // Backpressure with a full pipe
        got_res.delete();
        cyc(mk(1, 0, 7, 7, 11), IDLE, 1'b0);
        cyc(IDLE, mk(1, 0, 8, 8, 12), 1'b0);
        cyc(mk(1, 0, 9, 9, 13), IDLE, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(mk(1, 0, 1, 1, 14), mk(1, 0, 1, 1, 15), 1'b0);
            chk($sformatf("stall_hold%0d", k), mul_stall_o, 1);
        end
        for (int k = 0; k < 8; k++) cyc(IDLE, IDLE, 1'b1);
        chk("stall_rsp_count", got_res.size(), 3);

        // DIV encoding flagged, next MUL unaffected
        run_one("div", 1'b0, 3'b100, 32'd100, 32'd7, 5'd2, 32'h0);
        run_one("after_div", 1'b0, 3'b000, 32'd6, 32'd7, 5'd3, 32'd42);

        // Reset with ops in flight
        cyc(mk(1, 0, 11, 11, 1), IDLE, 1'b1);
        cyc(IDLE, mk(1, 0, 12, 12, 2), 1'b1);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(IDLE, IDLE, 1'b1);
            chk($sformatf("post_rst_valid%0d", k), rsp_valid_o, 0);
            chk($sformatf("post_rst_busy%0d", k), busy_o, 0);
        end

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            rq_t r0, r1;
            r0 = mk($urandom_range(0, 1), 3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 5'($urandom));
            r1 = mk($urandom_range(0, 1), 3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 5'($urandom));
            cyc(r0, r1, $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 8; k++) cyc(IDLE, IDLE, 1'b1);
        chk("drain_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
